// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the flagged sync FIFO.
// Pointer/count width helper used by the FIFO top.
package fifo_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 512;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_sync_flagged_if.sv
// Producer/consumer handshake bundle for fifo_sync_flagged.
// master = the blocks around the FIFO, slave = the FIFO.
interface fifo_sync_flagged_if #(
  parameter int W = 16
) ();

  logic         wen_a;
  logic [W-1:0] din_a;
  logic         ren_b;
  logic [W-1:0] dout_b;
  logic         valid_b;

  modport master (
    output wen_a, din_a, ren_b,
    input  dout_b, valid_b
  );

  modport slave (
    input  wen_a, din_a, ren_b,
    output dout_b, valid_b
  );

endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port.
// Read-before-write on an address collision; storage is not reset.
module fifo_sdp_ram #(
  parameter int W  = 16,
  parameter int D  = 512,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [W-1:0]  wd,
  input  logic          re,
  input  logic [AW-1:0] ra,
  output logic [W-1:0]  rq
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rq <= mem[ra];
  end

endmodule

// File: rtl/fifo_sync_flagged.sv
// Single-clock FIFO with count, almost flags, sticky errors, flush.
// Define FIFO_FWFT_EN for first-word-fall-through output.
module fifo_sync_flagged
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_WIDTH,
  parameter int FIFO_DEPTH = DEF_DEPTH,
  localparam int BITS = $clog2(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  fifo_sync_flagged_if.slave bus,
  output logic            full,
  output logic            empty,
  output logic [BITS:0]   count,
  input  logic [BITS:0]   af_thresh,
  input  logic [BITS:0]   ae_thresh,
  output logic            almost_full,
  output logic            almost_empty,
  input  logic            err_clr,
  output logic            overflow,
  output logic            underflow
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam logic [PW-1:0] ONE =
    {{BITS{1'b0}}, 1'b1};
  localparam logic [PW-1:0] DEPTH_C =
    {1'b1, {BITS{1'b0}}};

  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW-1:0]         cnt_n;
  logic                  go, ram_empty;
  logic                  wr_acc, rd_acc;
  logic                  ram_we, ram_re, byp_ld;
  logic                  ovf_set, unf_set;
  logic                  vld, vld_n, sel;
  logic [FIFO_WIDTH-1:0] byp, ram_q;

  fifo_sdp_ram #(
    .W (FIFO_WIDTH),
    .D (FIFO_DEPTH)
  ) u_ram (
    .clk (clk),
    .we  (ram_we),
    .wa  (wr_ptr[BITS-1:0]),
    .wd  (bus.din_a),
    .re  (ram_re),
    .ra  (rd_ptr[BITS-1:0]),
    .rq  (ram_q)
  );

  assign ram_empty = (wr_ptr == rd_ptr);

`ifdef FIFO_FWFT_EN
  // count includes the output register
  assign empty = (count == '0);
  assign full  = (count == DEPTH_C);
`else
  assign empty = ram_empty;
  assign full  = ((wr_ptr ^ rd_ptr) == DEPTH_C);
`endif

  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);
  assign bus.valid_b  = vld;
  assign bus.dout_b   = sel ? byp : ram_q;

  always_comb begin
    go     = rst_n && !flush;
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    ram_we = 1'b0;
    ram_re = 1'b0;
    byp_ld = 1'b0;
    vld_n  = vld;
`ifdef FIFO_FWFT_EN
    rd_acc = go && bus.ren_b && vld;
    wr_acc = go && bus.wen_a
          && (!full || rd_acc);
    // head slot is free after this edge
    if (go && (!vld || rd_acc)) begin
      ram_re = !ram_empty;
      byp_ld = ram_empty && wr_acc;
    end
    ram_we = wr_acc && !byp_ld;
    if (ram_re || byp_ld) vld_n = 1'b1;
    else if (rd_acc)      vld_n = 1'b0;
`else
    rd_acc = go && bus.ren_b && !empty;
    wr_acc = go && bus.wen_a
          && (!full || rd_acc);
    ram_we = wr_acc;
    ram_re = rd_acc;
    vld_n  = rd_acc;
`endif
    ovf_set = go && bus.wen_a && !wr_acc;
    unf_set = go && bus.ren_b && !rd_acc;
    unique case ({wr_acc, rd_acc})
      2'b10:   cnt_n = count + ONE;
      2'b01:   cnt_n = count - ONE;
      default: cnt_n = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      vld       <= 1'b0;
      sel       <= 1'b1;
      byp       <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // a new error outranks a coincident clear
      overflow  <= ovf_set
                 | (overflow & ~err_clr);
      underflow <= unf_set
                 | (underflow & ~err_clr);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
        vld    <= 1'b0;
      end else begin
        if (ram_we) wr_ptr <= wr_ptr + ONE;
        if (ram_re) rd_ptr <= rd_ptr + ONE;
        count <= cnt_n;
        vld   <= vld_n;
        if (byp_ld) begin
          byp <= bus.din_a;
          sel <= 1'b1;
        end else if (ram_re) begin
          sel <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_sync_flagged.sv
// Scoreboard bench for fifo_sync_flagged (DEPTH 8, WIDTH 16).
// Covers the standard build, or the FWFT build with FIFO_FWFT_EN.
module tb_fifo_sync_flagged;
  import fifo_pkg::*;

  localparam int W = 16;
  localparam int D = 8;
  localparam int B = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         flush = 1'b0;
  logic         err_clr = 1'b0;
  logic [B:0]   af_thresh = 4'd6;
  logic [B:0]   ae_thresh = 4'd1;
  logic [B:0]   count;
  logic         full, empty;
  logic         almost_full, almost_empty;
  logic         overflow, underflow;

  int total = 0;
  int bad = 0;
  logic [W-1:0] model [$];
  logic [W-1:0] exp_q [$];

  fifo_sync_flagged_if #(.W(W)) bus ();

  fifo_sync_flagged #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (D)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .bus          (bus.slave),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .af_thresh    (af_thresh),
    .ae_thresh    (ae_thresh),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .err_clr      (err_clr),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, exp);
    end
  endtask

  // Pops the scoreboard whenever a word is delivered
  always @(negedge clk) begin
`ifdef FIFO_FWFT_EN
    if (rst_n && !flush && bus.valid_b && bus.ren_b) begin
`else
    if (bus.valid_b) begin
`endif
      if (exp_q.size() == 0)
        chk("unexpected_valid", 1, 0);
      else
        chk("data", bus.dout_b, exp_q.pop_front());
    end
  end

  task automatic cyc(input logic w,
                     input logic [W-1:0] d,
                     input logic r,
                     input logic e = 1'b0);
    bit racc, wacc;
    racc = r && (model.size() > 0);
    wacc = w && (model.size() < D || racc);
    if (racc) exp_q.push_back(model.pop_front());
    if (wacc) model.push_back(d);
    bus.wen_a = w;
    bus.din_a = d;
    bus.ren_b = r;
    err_clr = e;
    @(posedge clk);
    #1;
    bus.wen_a = 1'b0;
    bus.ren_b = 1'b0;
    err_clr = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model.delete();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    model.delete();
    exp_q.delete();
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_valid", bus.valid_b, 0);
    chk("rst_dout", bus.dout_b, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.wen_a = 1'b0;
    bus.din_a = '0;
    bus.ren_b = 1'b0;
    do_reset(2);

`ifdef FIFO_FWFT_EN
    cyc(1'b1, 16'h1234, 1'b0);
    chk("fwft_valid", bus.valid_b, 1);
    chk("fwft_dout", bus.dout_b, 16'h1234);
    chk("fwft_empty", empty, 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1'(($urandom_range(0, 3)) != 0),
          W'($urandom),
          1'($urandom_range(0, 1)));
      chk("fwft_count", count, model.size());
      chk("fwft_bubble", bus.valid_b,
          32'(model.size() != 0));
    end
    for (int k = 0; k < 20 && model.size() > 0; k++)
      cyc(1'b0, '0, 1'b1);
    chk("fwft_drained", count, 0);
    cyc(1'b0, '0, 1'b1);
    chk("fwft_unf", underflow, 1);
    cyc(1'b0, '0, 1'b0, 1'b1);
`else
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, W'(i), 1'b0);
      chk("fill_count", count, i);
      chk("fill_af", almost_full, 32'(i >= 6));
      chk("fill_full", full, 32'(i == 8));
      chk("fill_ae", almost_empty, 32'(i <= 1));
    end
    cyc(1'b1, 16'h0009, 1'b0);
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("ovf_clr", overflow, 0);

    for (int i = 1; i <= 8; i++) begin
      cyc(1'b0, '0, 1'b1);
      chk("drain_valid", bus.valid_b, 1);
      chk("drain_dout", bus.dout_b, i);
      chk("drain_count", count, 8 - i);
    end
    cyc(1'b0, '0, 1'b1);
    chk("unf_set", underflow, 1);
    chk("unf_hold", bus.dout_b, 16'h0008);
    chk("unf_valid", bus.valid_b, 0);
    cyc(1'b0, '0, 1'b0, 1'b1);

    for (int i = 1; i <= 8; i++)
      cyc(1'b1, W'(16 + i), 1'b0);
    cyc(1'b1, 16'h00AA, 1'b1);
    chk("fullrw_count", count, 8);
    chk("fullrw_ovf", overflow, 0);
    chk("fullrw_dout", bus.dout_b, 16'h0011);
    for (int i = 0; i < 8; i++)
      cyc(1'b0, '0, 1'b1);
    chk("fullrw_last", bus.dout_b, 16'h00AA);

    cyc(1'b1, 16'h0055, 1'b1);
    chk("emptyrw_count", count, 1);
    chk("emptyrw_unf", underflow, 1);
    cyc(1'b0, '0, 1'b1);
    chk("emptyrw_dout", bus.dout_b, 16'h0055);
    cyc(1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, '0, 1'b0, 1'b1);
    chk("clr_idle_ovf", overflow, 0);
    chk("clr_idle_unf", underflow, 0);

    for (int i = 0; i < 5; i++)
      cyc(1'b1, W'(16'h0060 + i), 1'b0);
    chk("pre_flush", count, 5);
    do_flush();
    chk("flush_count", count, 0);
    chk("flush_empty", empty, 1);
    chk("flush_dout", bus.dout_b, 16'h0055);
    chk("flush_valid", bus.valid_b, 0);

    for (int i = 0; i < 8; i++)
      cyc(1'b1, W'(16'h0070 + i), 1'b0);
    cyc(1'b1, 16'h0099, 1'b0, 1'b1);
    chk("ovf_vs_clr", overflow, 1);
    do_flush();
`endif

    for (int i = 0; i < 4; i++)
      cyc(1'b1, W'(16'h0040 + i), 1'b0);
    chk("mid_count", count, 4);
    do_reset(1);

    chk("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
